// File: rtl/csr_trap_unit_pkg.sv
// Shared types, CSR numbers, field positions and reset constants for the
// machine/debug CSR and trap block.
package csr_trap_unit_pkg;

   typedef enum logic [11:0] {
      CSR_MSTATUS   = 12'h300,
      CSR_MIE       = 12'h304,
      CSR_MTVEC     = 12'h305,
      CSR_MSCRATCH  = 12'h340,
      CSR_MEPC      = 12'h341,
      CSR_MCAUSE    = 12'h342,
      CSR_MTVAL     = 12'h343,
      CSR_MIP       = 12'h344,
      CSR_DCSR      = 12'h7B0,
      CSR_DPC       = 12'h7B1,
      CSR_DSCRATCH0 = 12'h7B2
   } csr_num_e;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } priv_lvl_e;

   typedef struct packed {
      logic       irq_ext;
      logic       irq_int;
      logic [4:0] lower_cause;
   } exc_cause_t;

   localparam exc_cause_t EXC_CAUSE_IRQ_EXTERNAL_M =
      '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 5'd11};

   typedef struct packed {
      logic        irq_software;
      logic        irq_timer;
      logic        irq_external;
      logic [14:0] irq_fast;
   } irqs_t;

   typedef enum logic [2:0] {
      DBG_CAUSE_NONE    = 3'd0,
      DBG_CAUSE_EBREAK  = 3'd1,
      DBG_CAUSE_TRIGGER = 3'd2,
      DBG_CAUSE_HALTREQ = 3'd3,
      DBG_CAUSE_STEP    = 3'd4
   } dbg_cause_e;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned MSTATUS_MPP_LO   = 11;
   localparam int unsigned MSTATUS_MPP_HI   = 12;
   localparam int unsigned DCSR_EBREAKM_BIT = 15;
   localparam int unsigned DCSR_EBREAKU_BIT = 12;
   localparam int unsigned DCSR_STEP_BIT    = 2;
   localparam int unsigned DCSR_CAUSE_LO    = 6;
   localparam int unsigned DCSR_CAUSE_HI    = 8;

   localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
   localparam logic [31:0] IRQ_MASK     = 32'h7FFF_0888;
   localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FF00;
   localparam logic [31:0] EPC_MASK     = 32'hFFFF_FFFE;
   localparam logic [31:0] DCSR_MASK    = 32'h0000_91C7;
   localparam logic [31:0] FULL_MASK    = 32'hFFFF_FFFF;
   localparam logic [31:0] ZERO_RST     = 32'h0000_0000;

   // Only U and M are implemented; unsupported levels collapse to U.
   function automatic logic [1:0] warl_priv(input logic [1:0] p);
      if ((p == PRIV_LVL_U) || (p == PRIV_LVL_M)) begin
         return p;
      end
      return PRIV_LVL_U;
   endfunction

endpackage

// File: rtl/csr_trap_reg.sv
// One stored CSR: bits outside WR_MASK are hardwired to their RESET_VAL,
// the rest load wr_data_i when wr_en_i is high.
module csr_trap_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter logic [WIDTH-1:0] WR_MASK   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] val_q;
   logic [WIDTH-1:0] val_d;

   assign val_d = (wr_data_i & WR_MASK) | (RESET_VAL & ~WR_MASK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q <= RESET_VAL;
      end else if (wr_en_i) begin
         val_q <= val_d;
      end
   end

   assign rd_data_o = val_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode and debug CSR file with trap entry/return sequencing.
// Reads are combinational; every state change commits on the next clk edge.
module csr_trap_unit
   import csr_trap_unit_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST     = 32'h0000_0000,
   parameter logic [3:0]  DBG_XDEBUGVER = 4'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_access_i,
   input  logic [1:0]  csr_op_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        illegal_csr_o,
   input  logic [31:0] pc_i,
   input  logic [6:0]  exc_cause_i,
   input  logic [31:0] csr_mtval_i,
   input  logic        csr_save_i,
   input  logic        csr_save_cause_i,
   input  logic        csr_restore_mret_i,
   input  logic        csr_restore_dret_i,
   input  logic        debug_csr_save_i,
   input  logic [2:0]  debug_cause_i,
   input  logic        debug_mode_i,
   input  logic        irq_software_i,
   input  logic        irq_timer_i,
   input  logic        irq_external_i,
   input  logic [14:0] irq_fast_i,
   output logic        irq_pending_o,
   output logic [17:0] irqs_o,
   output logic        csr_mstatus_mie_o,
   output logic [1:0]  priv_mode_o,
   output logic        debug_single_step_o,
   output logic        debug_ebreakm_o,
   output logic        debug_ebreaku_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_depc_o,
   output logic [31:0] csr_mtvec_o
);

   localparam logic [31:0] MTVEC_RST_VAL = {MTVEC_RST[31:8], 8'h01};
   localparam logic [31:0] DCSR_RST_VAL  = {DBG_XDEBUGVER, 26'b0, 2'b11};

   csr_op_e    op;
   exc_cause_t cause;
   irqs_t      irqs;

   logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [31:0] mtval_q, mip_q, dcsr_q, dpc_q, dscratch0_q;
   logic [31:0] mstatus_d, mepc_d, mcause_d, mtval_d, dcsr_d, dpc_d, mip_d;
   logic        mstatus_we, mie_we, mtvec_we, mscratch_we, mepc_we, mcause_we;
   logic        mtval_we, dcsr_we, dpc_we, dscratch0_we;
   logic [1:0]  priv_q, priv_d;

   logic        csr_mapped, dbg_csr, strobe_any, csr_we;
   logic [31:0] wval, mip_en;

   assign op    = csr_op_e'(csr_op_i);
   assign cause = exc_cause_i;

   always_comb begin
      csr_rdata_o = '0;
      csr_mapped  = 1'b1;
      case (csr_addr_i)
         CSR_MSTATUS:   csr_rdata_o = mstatus_q;
         CSR_MIE:       csr_rdata_o = mie_q;
         CSR_MTVEC:     csr_rdata_o = mtvec_q;
         CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
         CSR_MEPC:      csr_rdata_o = mepc_q;
         CSR_MCAUSE:    csr_rdata_o = mcause_q;
         CSR_MTVAL:     csr_rdata_o = mtval_q;
         CSR_MIP:       csr_rdata_o = mip_q;
         CSR_DCSR:      csr_rdata_o = dcsr_q;
         CSR_DPC:       csr_rdata_o = dpc_q;
         CSR_DSCRATCH0: csr_rdata_o = dscratch0_q;
         default:       csr_mapped  = 1'b0;
      endcase
   end

   assign dbg_csr = (csr_addr_i == CSR_DCSR) || (csr_addr_i == CSR_DPC) ||
                    (csr_addr_i == CSR_DSCRATCH0);

   assign illegal_csr_o = csr_access_i &
                          (~csr_mapped |
                           ((op != CSR_OP_READ) && (csr_addr_i == CSR_MIP)) |
                           (dbg_csr & ~debug_mode_i) |
                           (priv_q == PRIV_LVL_U));

   always_comb begin
      wval = csr_wdata_i;
      case (op)
         CSR_OP_SET:   wval = csr_rdata_o | csr_wdata_i;
         CSR_OP_CLEAR: wval = csr_rdata_o & ~csr_wdata_i;
         default:      wval = csr_wdata_i;
      endcase
   end

   // Controller strobes own the cycle; a same-cycle software write is dropped.
   assign strobe_any = csr_save_i | csr_restore_mret_i | csr_restore_dret_i |
                       debug_csr_save_i;
   assign csr_we     = csr_access_i & (op != CSR_OP_READ) & ~illegal_csr_o &
                       ~strobe_any;

   assign mie_we       = csr_we && (csr_addr_i == CSR_MIE);
   assign mtvec_we     = csr_we && (csr_addr_i == CSR_MTVEC);
   assign mscratch_we  = csr_we && (csr_addr_i == CSR_MSCRATCH);
   assign dscratch0_we = csr_we && (csr_addr_i == CSR_DSCRATCH0);

   always_comb begin
      mstatus_d  = mstatus_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      dcsr_d     = dcsr_q;
      dpc_d      = dpc_q;
      priv_d     = priv_q;
      mstatus_we = 1'b0;
      mepc_we    = 1'b0;
      mcause_we  = 1'b0;
      mtval_we   = 1'b0;
      dcsr_we    = 1'b0;
      dpc_we     = 1'b0;

      if (debug_csr_save_i) begin
         dpc_d   = pc_i;
         dpc_we  = 1'b1;
         dcsr_d[DCSR_CAUSE_HI:DCSR_CAUSE_LO] = debug_cause_i;
         dcsr_d[1:0] = priv_q;
         dcsr_we = 1'b1;
         priv_d  = PRIV_LVL_M;
      end else if (csr_save_i && csr_save_cause_i) begin
         mepc_d    = pc_i;
         mepc_we   = 1'b1;
         mcause_d  = {cause.irq_ext | cause.irq_int, cause.irq_int, 25'b0,
                      cause.lower_cause};
         mcause_we = 1'b1;
         mtval_d   = csr_mtval_i;
         mtval_we  = 1'b1;
         mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
         mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
         mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
         mstatus_we = 1'b1;
         priv_d     = PRIV_LVL_M;
      end else if (csr_restore_mret_i) begin
         mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
         mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
         mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_LVL_U;
         mstatus_we = 1'b1;
         priv_d     = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end else if (csr_restore_dret_i) begin
         priv_d = dcsr_q[1:0];
      end else if (csr_we) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               mstatus_d = wval;
               mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] =
                  warl_priv(wval[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
               mstatus_we = 1'b1;
            end
            CSR_MEPC: begin
               mepc_d  = wval;
               mepc_we = 1'b1;
            end
            CSR_MCAUSE: begin
               mcause_d  = wval;
               mcause_we = 1'b1;
            end
            CSR_MTVAL: begin
               mtval_d  = wval;
               mtval_we = 1'b1;
            end
            CSR_DCSR: begin
               // cause is only ever written by debug entry
               dcsr_d = wval;
               dcsr_d[DCSR_CAUSE_HI:DCSR_CAUSE_LO] = dcsr_q[DCSR_CAUSE_HI:DCSR_CAUSE_LO];
               dcsr_d[1:0] = warl_priv(wval[1:0]);
               dcsr_we = 1'b1;
            end
            CSR_DPC: begin
               dpc_d  = wval;
               dpc_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         priv_q <= PRIV_LVL_M;
      end else begin
         priv_q <= priv_d;
      end
   end

   assign mip_d = {1'b0, irq_fast_i, 4'b0, irq_external_i, 3'b0, irq_timer_i,
                   3'b0, irq_software_i, 3'b0};

   csr_trap_reg #(.WIDTH(32), .RESET_VAL(MSTATUS_RST), .WR_MASK(MSTATUS_MASK)) u_mstatus (
      .clk(clk), .rst(rst), .wr_en_i(mstatus_we), .wr_data_i(mstatus_d), .rd_data_o(mstatus_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(IRQ_MASK)) u_mie (
      .clk(clk), .rst(rst), .wr_en_i(mie_we), .wr_data_i(wval), .rd_data_o(mie_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(MTVEC_RST_VAL), .WR_MASK(MTVEC_MASK)) u_mtvec (
      .clk(clk), .rst(rst), .wr_en_i(mtvec_we), .wr_data_i(wval), .rd_data_o(mtvec_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(FULL_MASK)) u_mscratch (
      .clk(clk), .rst(rst), .wr_en_i(mscratch_we), .wr_data_i(wval), .rd_data_o(mscratch_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(EPC_MASK)) u_mepc (
      .clk(clk), .rst(rst), .wr_en_i(mepc_we), .wr_data_i(mepc_d), .rd_data_o(mepc_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(FULL_MASK)) u_mcause (
      .clk(clk), .rst(rst), .wr_en_i(mcause_we), .wr_data_i(mcause_d), .rd_data_o(mcause_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(FULL_MASK)) u_mtval (
      .clk(clk), .rst(rst), .wr_en_i(mtval_we), .wr_data_i(mtval_d), .rd_data_o(mtval_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(IRQ_MASK)) u_mip (
      .clk(clk), .rst(rst), .wr_en_i(1'b1), .wr_data_i(mip_d), .rd_data_o(mip_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(DCSR_RST_VAL), .WR_MASK(DCSR_MASK)) u_dcsr (
      .clk(clk), .rst(rst), .wr_en_i(dcsr_we), .wr_data_i(dcsr_d), .rd_data_o(dcsr_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(EPC_MASK)) u_dpc (
      .clk(clk), .rst(rst), .wr_en_i(dpc_we), .wr_data_i(dpc_d), .rd_data_o(dpc_q));
   csr_trap_reg #(.WIDTH(32), .RESET_VAL(ZERO_RST), .WR_MASK(FULL_MASK)) u_dscratch0 (
      .clk(clk), .rst(rst), .wr_en_i(dscratch0_we), .wr_data_i(wval), .rd_data_o(dscratch0_q));

   assign mip_en = mip_q & mie_q;
   assign irqs   = '{irq_software: mip_en[3], irq_timer: mip_en[7],
                     irq_external: mip_en[11], irq_fast: mip_en[30:16]};

   assign irq_pending_o       = |mip_en;
   assign irqs_o              = irqs;
   assign csr_mstatus_mie_o   = mstatus_q[MSTATUS_MIE_BIT];
   assign priv_mode_o         = priv_q;
   assign debug_single_step_o = dcsr_q[DCSR_STEP_BIT];
   assign debug_ebreakm_o     = dcsr_q[DCSR_EBREAKM_BIT];
   assign debug_ebreaku_o     = dcsr_q[DCSR_EBREAKU_BIT];
   assign csr_mepc_o          = mepc_q;
   assign csr_depc_o          = dpc_q;
   assign csr_mtvec_o         = mtvec_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit with hand-computed expectations.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csr_access_i, csr_save_i, csr_save_cause_i;
   logic        csr_restore_mret_i, csr_restore_dret_i, debug_csr_save_i, debug_mode_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i, pc_i, csr_mtval_i;
   logic [6:0]  exc_cause_i;
   logic [2:0]  debug_cause_i;
   logic        irq_software_i, irq_timer_i, irq_external_i;
   logic [14:0] irq_fast_i;
   logic [31:0] csr_rdata_o, csr_mepc_o, csr_depc_o, csr_mtvec_o;
   logic        illegal_csr_o, irq_pending_o, csr_mstatus_mie_o;
   logic [17:0] irqs_o;
   logic [1:0]  priv_mode_o;
   logic        debug_single_step_o, debug_ebreakm_o, debug_ebreaku_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   csr_trap_unit #(.MTVEC_RST(32'h0000_1234), .DBG_XDEBUGVER(4'd4)) dut (
      .clk(clk), .rst(rst),
      .csr_access_i(csr_access_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .illegal_csr_o(illegal_csr_o),
      .pc_i(pc_i), .exc_cause_i(exc_cause_i), .csr_mtval_i(csr_mtval_i),
      .csr_save_i(csr_save_i), .csr_save_cause_i(csr_save_cause_i),
      .csr_restore_mret_i(csr_restore_mret_i), .csr_restore_dret_i(csr_restore_dret_i),
      .debug_csr_save_i(debug_csr_save_i), .debug_cause_i(debug_cause_i),
      .debug_mode_i(debug_mode_i),
      .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
      .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i),
      .irq_pending_o(irq_pending_o), .irqs_o(irqs_o), .csr_mstatus_mie_o(csr_mstatus_mie_o),
      .priv_mode_o(priv_mode_o), .debug_single_step_o(debug_single_step_o),
      .debug_ebreakm_o(debug_ebreakm_o), .debug_ebreaku_o(debug_ebreaku_o),
      .csr_mepc_o(csr_mepc_o), .csr_depc_o(csr_depc_o), .csr_mtvec_o(csr_mtvec_o)
   );

   task automatic idle();
      csr_access_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
      pc_i = 0; exc_cause_i = 0; csr_mtval_i = 0; csr_save_i = 0; csr_save_cause_i = 0;
      csr_restore_mret_i = 0; csr_restore_dret_i = 0; debug_csr_save_i = 0; debug_cause_i = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic csr_set_inputs(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      csr_access_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
   endtask

   task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      csr_set_inputs(op, a, wd);
      tick();
   endtask

   task automatic csr_rd(input logic [11:0] a);
      csr_set_inputs(2'd0, a, 32'h0);
      #1;
   endtask

   task automatic trap(input logic [31:0] pc, input logic [6:0] cause, input logic [31:0] tval);
      csr_save_i = 1; csr_save_cause_i = 1; pc_i = pc; exc_cause_i = cause; csr_mtval_i = tval;
      tick();
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus: got %h want %h", csr_rdata_o, 32'h0000_1800); end
      n_cmp++; if (priv_mode_o !== 2'b11) begin n_fail++; $display("FAIL rst_priv: got %b want 11", priv_mode_o); end
      n_cmp++; if ({irq_pending_o, irqs_o, csr_mstatus_mie_o} !== 20'h0) begin n_fail++; $display("FAIL rst_irq: got %b/%h/%b want 0", irq_pending_o, irqs_o, csr_mstatus_mie_o); end
      n_cmp++; if ({debug_single_step_o, debug_ebreakm_o, debug_ebreaku_o} !== 3'b000) begin n_fail++; $display("FAIL rst_dbg_out: got %b want 000", {debug_single_step_o, debug_ebreakm_o, debug_ebreaku_o}); end
      n_cmp++; if (csr_mtvec_o !== 32'h0000_1201) begin n_fail++; $display("FAIL rst_mtvec: got %h want %h", csr_mtvec_o, 32'h0000_1201); end
      csr_rd(12'h7B0);
      n_cmp++; if (csr_rdata_o !== 32'h4000_0003) begin n_fail++; $display("FAIL rst_dcsr: got %h want %h", csr_rdata_o, 32'h4000_0003); end
      idle();
      csr_save_i = 1; csr_save_cause_i = 1; pc_i = 32'hABCD_0000;
      tick();
      n_cmp++; if (csr_mepc_o !== 32'h0) begin n_fail++; $display("FAIL rst_strobe_discard: got %h want 0", csr_mepc_o); end
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0000_1800) begin n_fail++; $display("FAIL post_rst_mstatus: got %h want %h", csr_rdata_o, 32'h0000_1800); end
      n_cmp++; if (priv_mode_o !== 2'b11 || irq_pending_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_priv_irq: got %b/%b want 11/0", priv_mode_o, irq_pending_o); end
      idle();
   endtask

   task automatic test_irq_pending();
      csr_do(2'd2, 12'h300, 32'h8);
      csr_do(2'd2, 12'h304, 32'h800);
      n_cmp++; if (csr_mstatus_mie_o !== 1'b1) begin n_fail++; $display("FAIL irq_mie: got %b want 1", csr_mstatus_mie_o); end
      irq_external_i = 1;
      #1;
      n_cmp++; if (irq_pending_o !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle: got %b want 0", irq_pending_o); end
      @(posedge clk); #1;
      n_cmp++; if (irq_pending_o !== 1'b1) begin n_fail++; $display("FAIL irq_next_cycle: got %b want 1", irq_pending_o); end
      n_cmp++; if (irqs_o !== 18'h08000) begin n_fail++; $display("FAIL irqs_ext: got %h want %h", irqs_o, 18'h08000); end
      csr_rd(12'h344);
      n_cmp++; if (csr_rdata_o !== 32'h0000_0800) begin n_fail++; $display("FAIL mip_ext: got %h want %h", csr_rdata_o, 32'h0000_0800); end
      irq_external_i = 0;
      tick();
      n_cmp++; if (irq_pending_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq_pending_o); end
   endtask

   task automatic test_trap_mret();
      trap(32'h8000_0104, 7'h4B, 32'h0);
      n_cmp++; if (csr_mepc_o !== 32'h8000_0104) begin n_fail++; $display("FAIL trap_mepc: got %h want %h", csr_mepc_o, 32'h8000_0104); end
      csr_rd(12'h342);
      n_cmp++; if (csr_rdata_o !== 32'h8000_000B) begin n_fail++; $display("FAIL trap_mcause: got %h want %h", csr_rdata_o, 32'h8000_000B); end
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0000_1880) begin n_fail++; $display("FAIL trap_mstatus: got %h want %h", csr_rdata_o, 32'h0000_1880); end
      idle();
      csr_restore_mret_i = 1; tick();
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0000_0088 || priv_mode_o !== 2'b11) begin n_fail++; $display("FAIL mret_state: got %h/%b want 00000088/11", csr_rdata_o, priv_mode_o); end
      idle();
      csr_restore_mret_i = 1; tick();
      n_cmp++; if (priv_mode_o !== 2'b00) begin n_fail++; $display("FAIL mret_to_u: got %b want 00", priv_mode_o); end
      csr_set_inputs(2'd1, 12'h340, 32'hDEAD);
      #1;
      n_cmp++; if (illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL umode_illegal: got %b want 1", illegal_csr_o); end
      tick();
      trap(32'h0000_0100, 7'h08, 32'h0);
      n_cmp++; if (priv_mode_o !== 2'b11) begin n_fail++; $display("FAIL ecall_priv: got %b want 11", priv_mode_o); end
      csr_rd(12'h342);
      n_cmp++; if (csr_rdata_o !== 32'h0000_0008) begin n_fail++; $display("FAIL ecall_mcause: got %h want %h", csr_rdata_o, 32'h0000_0008); end
      csr_rd(12'h340);
      n_cmp++; if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL umode_write_dropped: got %h want 0", csr_rdata_o); end
      idle();
   endtask

   task automatic test_write_vs_save();
      csr_set_inputs(2'd1, 12'h341, 32'h1234_5678);
      trap(32'h0000_2000, 7'h02, 32'h0);
      n_cmp++; if (csr_mepc_o !== 32'h0000_2000) begin n_fail++; $display("FAIL save_beats_write: got %h want %h", csr_mepc_o, 32'h0000_2000); end
      csr_do(2'd1, 12'h341, 32'h1234_5679);
      n_cmp++; if (csr_mepc_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mepc_bit0: got %h want %h", csr_mepc_o, 32'h1234_5678); end
   endtask

   task automatic test_warl_mip();
      csr_do(2'd1, 12'h300, 32'h0000_0800);
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL mpp_01: got %h want 0", csr_rdata_o); end
      csr_do(2'd1, 12'h300, 32'h0000_1000);
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL mpp_10: got %h want 0", csr_rdata_o); end
      csr_do(2'd1, 12'h300, 32'hFFFF_FFFF);
      csr_rd(12'h300);
      n_cmp++; if (csr_rdata_o !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_mask: got %h want %h", csr_rdata_o, 32'h0000_1888); end
      csr_do(2'd1, 12'h304, 32'hFFFF_FFFF);
      csr_rd(12'h304);
      n_cmp++; if (csr_rdata_o !== 32'h7FFF_0888) begin n_fail++; $display("FAIL mie_mask: got %h want %h", csr_rdata_o, 32'h7FFF_0888); end
      idle();
      irq_timer_i = 1;
      tick();
      n_cmp++; if (irq_pending_o !== 1'b1 || irqs_o !== 18'h10000) begin n_fail++; $display("FAIL timer_irq: got %b/%h want 1/10000", irq_pending_o, irqs_o); end
      csr_set_inputs(2'd1, 12'h344, 32'h0);
      #1;
      n_cmp++; if (illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL mip_write_illegal: got %b want 1", illegal_csr_o); end
      tick();
      csr_rd(12'h344);
      n_cmp++; if (csr_rdata_o !== 32'h0000_0080) begin n_fail++; $display("FAIL mip_unchanged: got %h want %h", csr_rdata_o, 32'h0000_0080); end
      idle();
      irq_timer_i = 0;
      csr_do(2'd1, 12'h305, 32'hFFFF_FFFF);
      n_cmp++; if (csr_mtvec_o !== 32'hFFFF_FF01) begin n_fail++; $display("FAIL mtvec_mask: got %h want %h", csr_mtvec_o, 32'hFFFF_FF01); end
   endtask

   task automatic test_debug();
      debug_mode_i = 0;
      csr_rd(12'h7B0);
      n_cmp++; if (illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL dcsr_no_dbg: got %b want 1", illegal_csr_o); end
      csr_rd(12'h340);
      n_cmp++; if (illegal_csr_o !== 1'b0) begin n_fail++; $display("FAIL mscratch_legal: got %b want 0", illegal_csr_o); end
      idle();
      csr_do(2'd1, 12'h300, 32'h0);
      csr_restore_mret_i = 1; tick();
      debug_csr_save_i = 1; debug_cause_i = 3'd3; pc_i = 32'h0000_0400;
      tick();
      n_cmp++; if (csr_depc_o !== 32'h0000_0400 || priv_mode_o !== 2'b11) begin n_fail++; $display("FAIL dbg_entry: got %h/%b want 00000400/11", csr_depc_o, priv_mode_o); end
      debug_mode_i = 1;
      csr_rd(12'h7B0);
      n_cmp++; if (csr_rdata_o !== 32'h4000_00C0 || illegal_csr_o !== 1'b0) begin n_fail++; $display("FAIL dbg_dcsr: got %h/%b want 400000C0/0", csr_rdata_o, illegal_csr_o); end
      idle();
      csr_do(2'd2, 12'h7B0, 32'h0000_8004);
      csr_rd(12'h7B0);
      n_cmp++; if (csr_rdata_o !== 32'h4000_80C4 || debug_ebreakm_o !== 1'b1 || debug_single_step_o !== 1'b1) begin n_fail++; $display("FAIL dcsr_set: got %h/%b/%b want 400080C4/1/1", csr_rdata_o, debug_ebreakm_o, debug_single_step_o); end
      idle();
      csr_restore_dret_i = 1; tick();
      n_cmp++; if (priv_mode_o !== 2'b00) begin n_fail++; $display("FAIL dret_priv: got %b want 00", priv_mode_o); end
      debug_mode_i = 0;
      trap(32'h0000_0300, 7'h08, 32'h0);
   endtask

   task automatic test_back_to_back();
      csr_set_inputs(2'd2, 12'h340, 32'h0000_00F0); @(posedge clk); #1;
      csr_set_inputs(2'd2, 12'h340, 32'h0000_000F); @(posedge clk); #1;
      csr_set_inputs(2'd3, 12'h340, 32'h0000_003C); @(posedge clk); #1;
      csr_rd(12'h340);
      n_cmp++; if (csr_rdata_o !== 32'h0000_00C3) begin n_fail++; $display("FAIL b2b_mscratch: got %h want %h", csr_rdata_o, 32'h0000_00C3); end
      csr_rd(12'h123);
      n_cmp++; if (csr_rdata_o !== 32'h0 || illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL unmapped: got %h/%b want 0/1", csr_rdata_o, illegal_csr_o); end
      idle();
      debug_csr_save_i = 1; debug_cause_i = 3'd4;
      trap(32'h0000_0800, 7'h02, 32'h55);
      n_cmp++; if (csr_depc_o !== 32'h0000_0800 || csr_mepc_o !== 32'h0000_0300) begin n_fail++; $display("FAIL dbg_over_trap: got %h/%h want 00000800/00000300", csr_depc_o, csr_mepc_o); end
      csr_rd(12'h7B0);
      n_cmp++; if (csr_rdata_o !== 32'h4000_8107) begin n_fail++; $display("FAIL dbg_over_trap_dcsr: got %h want %h", csr_rdata_o, 32'h4000_8107); end
      idle();
   endtask

   initial begin
      idle();
      debug_mode_i = 0; irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0; irq_fast_i = 0;
      test_reset();
      test_irq_pending();
      test_trap_mret();
      test_write_vs_save();
      test_warl_mip();
      test_debug();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Param MTVEC_RST, 32'h0000_0000, trap vector base at reset; bits[7:0] ignored.
REQ-002 Param DBG_XDEBUGVER, 4'd4, constant dcsr[31:28].
REQ-003 clk  in  1  sole clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 csr_access_i in 1; csr_op_i in 2 (READ/WRITE/SET/CLEAR); csr_addr_i in 12; csr_wdata_i in 32 — CSR instruction port.
REQ-006 csr_rdata_o out 32; illegal_csr_o out 1 — read data, illegal access flag.
REQ-007 pc_i in 32; exc_cause_i in 7 (exc_cause_t); csr_mtval_i in 32 — trap context.
REQ-008 csr_save_i, csr_save_cause_i, csr_restore_mret_i, csr_restore_dret_i, debug_csr_save_i  in  1 each — controller trap strobes.
REQ-009 debug_cause_i in 3 (dbg_cause_e); debug_mode_i in 1.
REQ-010 irq_software_i, irq_timer_i, irq_external_i in 1 each; irq_fast_i in 15.
REQ-011 irq_pending_o out 1; irqs_o out 18 (irqs_t); csr_mstatus_mie_o out 1; priv_mode_o out 2.
REQ-012 debug_single_step_o, debug_ebreakm_o, debug_ebreaku_o out 1 each; csr_mepc_o, csr_depc_o, csr_mtvec_o out 32.

Function
REQ-013 Map: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (RO), dcsr 0x7B0, dpc 0x7B1, dscratch0 0x7B2.
REQ-014 csr_rdata_o combinational from csr_addr_i; 0 for unmapped addresses.
REQ-015 Write value: WRITE=wdata, SET=q|wdata, CLEAR=q&~wdata, READ=none; commits at clk edge when csr_access_i=1, op!=READ, access legal.
REQ-016 illegal_csr_o=1 (combinational) when csr_access_i and: unmapped address, non-READ op to mip, debug CSR with debug_mode_i=0, or priv_mode_o=U; illegal access changes no state.
REQ-017 mstatus: MIE bit3, MPIE bit7, MPP[12:11]; other bits read 0; MPP WARL: 01/10 stored as 00.
REQ-018 mie writable bits 3,7,11,30:16 only; mtvec[1:0] reads 2'b01, [7:2] read 0; mepc/dpc bit0 forced 0.
REQ-019 mip registered: bit3=software, bit7=timer, bit11=external, [30:16]=fast; input at cycle N visible cycle N+1.
REQ-020 irq_pending_o = |(mip & mie); irqs_o = mip&mie fields; csr_mstatus_mie_o = mstatus.MIE.
REQ-021 Trap entry (csr_save_i & csr_save_cause_i): mepc<=pc_i, mcause<={irq_ext|irq_int, irq_int, 25'b0, lower_cause}, mtval<=csr_mtval_i, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M.
REQ-022 Debug entry (debug_csr_save_i): dpc<=pc_i, dcsr.cause[8:6]<=debug_cause_i, dcsr.prv<=priv, priv<=M; mstatus unchanged.
REQ-023 mret: MIE<=MPIE, MPIE<=1, priv<=MPP, MPP<=U; dret: priv<=dcsr.prv.
REQ-024 Priority per cycle: debug entry > trap entry > mret > dret > CSR write; any strobe suppresses the CSR write that cycle.
REQ-025 dcsr: ebreakm bit15, ebreaku bit12, step bit2, prv[1:0] (WARL as MPP), cause RO; drives debug_* outputs.
REQ-026 csr_mepc_o/csr_depc_o/csr_mtvec_o = stored mepc/dpc/mtvec.

Reset
REQ-027 While rst=1: priv=M, mstatus MPP=11 other bits 0, mie/mip/mscratch/mepc/mcause/mtval/dpc/dscratch0=0, mtvec=MTVEC_RST|1, dcsr={DBG_XDEBUGVER,0…,prv=11}.
REQ-028 Resulting outputs: irq_pending_o=0, irqs_o=0, csr_mstatus_mie_o=0, priv_mode_o=11, debug_* =0; in-flight strobes discarded.

Structure
REQ-029 pkg holds csr_num_e, csr_op_e, priv_lvl_e, exc_cause_t, irqs_t, dbg_cause_e, register reset constants.
REQ-030 One sub-module csr_trap_reg (width, reset value, write mask params) instantiated per stored CSR.

Verification
REQ-031 Reset release -> rdata(0x300)=0x0000_1800, priv_mode_o=11, irq_pending_o=0.
REQ-032 SET 0x300 wdata=8, SET 0x304 wdata=0x800, irq_external_i=1 cycle N -> irq_pending_o=1 cycle N+1, csr_mstatus_mie_o=1.
REQ-033 Trap entry pc_i=0x8000_0104, cause=ExcCauseIrqExternalM, mtval=0 -> mepc=0x8000_0104, mcause=0x8000_000B, MIE=0, MPIE=1; then mret -> MIE=1, priv=11, MPP=00.
REQ-034 CSR WRITE 0x341 concurrent with csr_save_i -> mepc=pc_i, write discarded.
REQ-035 debug_mode_i=0, READ 0x7B0 -> illegal_csr_o=1; debug_csr_save_i with cause=HALTREQ(3) -> dcsr[8:6]=3, dpc=pc_i; dret -> priv restored.
REQ-036 WRITE 0x300 MPP=01 -> reads back MPP=00; WRITE 0x344 -> illegal_csr_o=1, mip unchanged.
